// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU function codes, MAC sequencer states and Q1.7 limits
package alu_pkg;
  typedef enum logic [1:0] {
    RA    = 2'b00,
    RB    = 2'b01,
    RADD  = 2'b10,
    R_mul = 2'b11
  } alu_func_t;
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MUL,
    ADD,
    DONE
  } mac_state_t;
  localparam logic signed [7:0] Q_MAX = 8'sh7f;
  localparam logic signed [7:0] Q_MIN = 8'sh80;
endpackage

// File: rtl/mac_sat_detect.sv
// mac_sat_detect: signed overflow detect/saturate for acc+prod (a,b in, s=raw sum in, y=saturated, ovf); built only under MAC_SAT_EN
`ifdef MAC_SAT_EN
module mac_sat_detect
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] s,
  output logic [7:0] y,
  output logic       ovf
);
  always_comb begin
    ovf = (a[7] == b[7]) && (s[7] != a[7]);
    y   = ovf ? (a[7] ? Q_MIN : Q_MAX) : s;
  end
endmodule
`endif

// File: rtl/alu_mac_sequencer.sv
// alu_mac_sequencer: Q1.7 MAC over len x/y pairs via shared ALU (start/len, in_valid/in_ready x y, out_valid/out_ready result, busy, alu_a/alu_b/alu_func/alu_result; sat port under MAC_SAT_EN)
module alu_mac_sequencer
  import alu_pkg::*;
#(
  parameter int n     = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [n-1:0]     x,
  input  logic [n-1:0]     y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [n-1:0]     result,
  output logic             busy,
  output logic [n-1:0]     alu_a,
  output logic [n-1:0]     alu_b,
  output alu_func_t        alu_func,
  input  logic [n-1:0]     alu_result
`ifdef MAC_SAT_EN
  ,
  output logic             sat
`endif
);
  mac_state_t       state, nxt;
  logic [n-1:0]     acc, prod, xr, yr, acc_sum;
  logic [LEN_W-1:0] rem;
`ifdef MAC_SAT_EN
  logic ovf;
  mac_sat_detect u_sat (
    .a  (acc),
    .b  (prod),
    .s  (alu_result),
    .y  (acc_sum),
    .ovf(ovf)
  );
  always_ff @(posedge clk)
    if (!n_reset) sat <= 1'b0;
    else if (state == IDLE && start) sat <= 1'b0;
    else if (state == ADD && ovf) sat <= 1'b1;
`else
  assign acc_sum = alu_result;
`endif
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = start ? (len == '0 ? DONE : LOAD) : IDLE;
      LOAD:    nxt = in_valid ? MUL : LOAD;
      MUL:     nxt = ADD;
      ADD:     nxt = rem == LEN_W'(1) ? DONE : LOAD;
      DONE:    nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state == LOAD;
    out_valid = state == DONE;
    busy      = state != IDLE;
    result    = acc;
    alu_func  = state == MUL ? R_mul : state == ADD ? RADD : RA;
    alu_a     = state == MUL ? xr : acc;
    alu_b     = state == MUL ? yr : state == ADD ? prod : '0;
  end
  always_ff @(posedge clk)
    if (!n_reset) begin
      state <= IDLE;
      acc   <= '0;
      prod  <= '0;
      rem   <= '0;
      xr    <= '0;
      yr    <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        acc <= '0;
        rem <= len;
      end
      if (in_ready && in_valid) begin
        xr <= x;
        yr <= y;
      end
      if (state == MUL) prod <= alu_result;
      if (state == ADD) begin
        acc <= acc_sum;
        rem <= rem - LEN_W'(1);
      end
    end
endmodule

// File: tb/tb_alu_mac_sequencer.sv
// tb_alu_mac_sequencer: directed self-checking bench with a behavioural ALU beside the sequencer
module tb_alu_mac_sequencer;
  import alu_pkg::*;
  logic        clk = 0, n_reset = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [3:0]  len = 0;
  logic [7:0]  x = 0, y = 0;
  logic        in_ready, out_valid, busy;
  logic [7:0]  result, alu_a, alu_b, alu_result;
  alu_func_t   alu_func;
  logic signed [15:0] p;
  logic [7:0]  xs[4], ys[4];
  int          checks = 0, failures = 0;
`ifdef MAC_SAT_EN
  logic sat;
  localparam logic [7:0] SAT_RES = 8'd127;
`else
  localparam logic [7:0] SAT_RES = 8'd122;
`endif
  always #5 clk = ~clk;
  alu_mac_sequencer #(.n(8), .LEN_W(4)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_func  (alu_func),
    .alu_result(alu_result)
`ifdef MAC_SAT_EN
    ,
    .sat       (sat)
`endif
  );
  always_comb begin
    p = $signed(alu_a) * $signed(alu_b);
    alu_result = alu_func == RA ? alu_a : alu_func == RB ? alu_b :
                 alu_func == RADD ? alu_a + alu_b : p[14:7];
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic mac(input string tag, input int l, input int stall, input int exp_lat,
                     input logic [7:0] exp_res);
    int k, s, lat;
    logic hs;
    k = 0;
    s = stall;
    start = 1;
    len = 4'(l);
    @(negedge clk);
    start = 0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready && s > 0) begin
        chk({tag, "_stall_func"}, alu_func, RA);
        in_valid = 0;
        s--;
      end else in_valid = 1;
      x = xs[k % 4];
      y = ys[k % 4];
      hs = in_ready && in_valid;
      @(negedge clk);
      lat++;
      if (hs) k++;
    end
    in_valid = 0;
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_result"}, result, exp_res);
  endtask
  task automatic take_out(input string tag);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({tag, "_idle"}, busy, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_func", alu_func, RA);
    chk("rst_alu_b", alu_b, 0);
    n_reset = 1;
    @(negedge clk);
    xs = '{8'd64, 8'd0, 8'd0, 8'd0};
    ys = '{8'd64, 8'd0, 8'd0, 8'd0};
    mac("single", 1, 0, 4, 8'd32);
    take_out("single");
    xs = '{8'd64, 8'hc0, 8'd96, 8'd0};
    ys = '{8'd64, 8'd64, 8'd64, 8'd0};
    mac("three", 3, 0, 10, 8'd48);
    take_out("three");
    xs = '{8'd127, 8'd127, 8'd127, 8'd0};
    ys = '{8'd127, 8'd127, 8'd127, 8'd0};
    mac("satur", 3, 0, 10, SAT_RES);
`ifdef MAC_SAT_EN
    chk("satur_flag", sat, 1);
`endif
    for (int i = 0; i < 5; i++) begin
      start = 1;
      len = 4'd2;
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, SAT_RES);
    end
    start = 0;
    take_out("bp");
    chk("bp_out_valid", out_valid, 0);
    xs = '{8'd64, 8'd0, 8'd0, 8'd0};
    ys = '{8'd64, 8'd0, 8'd0, 8'd0};
    mac("stall", 1, 4, 8, 8'd32);
    take_out("stall");
    mac("len0", 0, 0, 1, 8'd0);
    take_out("len0");
    xs = '{8'h80, 8'd0, 8'd0, 8'd0};
    ys = '{8'h80, 8'd0, 8'd0, 8'd0};
    mac("wrap", 1, 0, 4, 8'h80);
    take_out("wrap");
    start = 1;
    len = 4'd3;
    in_valid = 1;
    x = 8'd64;
    y = 8'd64;
    repeat (5) begin
      @(negedge clk);
      start = 0;
    end
    chk("rst_mid_mul", alu_func, R_mul);
    n_reset = 0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_result", result, 0);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_ready", in_ready, 0);
    n_reset = 1;
    in_valid = 0;
    repeat (3) @(negedge clk);
    chk("rst_mid_after", out_valid, 0);
    chk("rst_mid_idle", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
